// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC1 on key load, then one PC2 round key per handshake.
// Optional DES_KEY_PARITY_CHECK_EN rejects keys with any even-parity byte.
module des_key_schedule #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [1:64] key,
  input  logic        decrypt,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [1:48] rk,
  output logic [3:0]  rk_round,
  output logic        rk_last,
  output logic        parity_err
);

  localparam int unsigned HALF_W = 28;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(i + 1)] = k[7'(PC1_TAB[i])];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(i + 1)] = cd[6'(PC2_TAB[i])];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 rotate by one; all others by two.
  function automatic logic shift_two(input logic [CNT_W-1:0] n);
    return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  function automatic logic [HALF_W-1:0] rotl(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]} : {x[HALF_W-2:0], x[HALF_W-1]};
  endfunction

  function automatic logic [HALF_W-1:0] rotr(input logic [HALF_W-1:0] x, input logic two);
    return two ? {x[1:0], x[HALF_W-1:2]} : {x[0], x[HALF_W-1:1]};
  endfunction

  state_t              state_q;
  logic [HALF_W-1:0]   c_q, d_q, c_d, d_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    emit_q, emit_d;
  logic                dec_q;
  logic                key_ready_q, rk_valid_q, rk_last_q;
  logic [3:0]          rk_round_q;
  logic [1:56]         pc1_cd;
  logic [HALF_W-1:0]   c0, d0;
  logic                parity_ok;
  logic                accept, advance, finish;

  assign pc1_cd = pc1(key);
  assign c0     = pc1_cd[1:28];
  assign d0     = pc1_cd[29:56];

`ifdef DES_KEY_PARITY_CHECK_EN
  function automatic logic odd_parity_ok(input logic [1:64] k);
    logic ok;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) if (!(^k[7'(8 * b + 1) +: 8])) ok = 1'b0;
    return ok;
  endfunction

  logic parity_err_q;

  assign parity_ok = odd_parity_ok(key);

  // Every attempt in IDLE updates the flag: set on reject, cleared on clean accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else if (key_valid && key_ready_q) begin
      parity_err_q <= !parity_ok;
    end
  end

  assign parity_err = parity_err_q;
`else
  logic unused_parity_bits;

  assign unused_parity_bits = ^{key[8], key[16], key[24], key[32],
                                key[40], key[48], key[56], key[64]};
  assign parity_ok  = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign accept  = key_valid && key_ready_q && parity_ok;
  assign advance = rk_valid_q && rk_ready && !rk_last_q;
  assign finish  = rk_valid_q && rk_ready && rk_last_q;

  // Next C/D and counters: decrypt starts at K16 (full rotation) and rotates right.
  always_comb begin
    c_d    = c_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    emit_d = emit_q;
    if (accept) begin
      emit_d = 5'd1;
      if (decrypt) begin
        c_d   = c0;
        d_d   = d0;
        cnt_d = 5'd16;
      end else begin
        c_d   = rotl(c0, 1'b0);
        d_d   = rotl(d0, 1'b0);
        cnt_d = 5'd1;
      end
    end else if (advance) begin
      emit_d = emit_q + 5'd1;
      if (dec_q) begin
        c_d   = rotr(c_q, shift_two(cnt_q));
        d_d   = rotr(d_q, shift_two(cnt_q));
        cnt_d = cnt_q - 5'd1;
      end else begin
        cnt_d = cnt_q + 5'd1;
        c_d   = rotl(c_q, shift_two(cnt_q + 5'd1));
        d_d   = rotl(d_q, shift_two(cnt_q + 5'd1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      emit_q      <= '0;
      dec_q       <= 1'b0;
      key_ready_q <= 1'b1;
      rk_valid_q  <= 1'b0;
      rk_last_q   <= 1'b0;
      rk_round_q  <= '0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      emit_q <= emit_d;
      if (accept || advance) begin
        rk_round_q <= 4'(cnt_d - 5'd1);
        rk_last_q  <= (emit_d == 5'(ROUNDS));
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= RUN;
            dec_q       <= decrypt;
            key_ready_q <= 1'b0;
            rk_valid_q  <= 1'b1;
          end
        end
        RUN: begin
          if (finish) begin
            state_q     <= IDLE;
            key_ready_q <= 1'b1;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk        = pc2({c_q, d_q});
  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk_round  = rk_round_q;
  assign rk_last   = rk_last_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: known-answer round keys, stall, reset, ROUNDS=2, parity.
module tb_des_key_schedule;

  typedef struct packed {
    logic [47:0] rk;
    logic [3:0]  rnd;
    logic        last;
  } exp_t;

  localparam logic [47:0] KT [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };
  localparam logic [63:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_BAD  = 64'h133457799BBCDFF0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        key_valid0 = 1'b0, key_ready0, dec0 = 1'b0, rk_valid0, rk_ready0 = 1'b1;
  logic [63:0] key0 = '0;
  logic [47:0] rk0;
  logic [3:0]  rk_round0;
  logic        rk_last0, parity_err0;

  logic        key_valid2 = 1'b0, key_ready2, dec2 = 1'b0, rk_valid2, rk_ready2 = 1'b1;
  logic [63:0] key2 = '0;
  logic [47:0] rk2;
  logic [3:0]  rk_round2;
  logic        rk_last2, parity_err2;

  int checks = 0;
  int errors = 0;
  exp_t sb0[$];
  exp_t sb2[$];

  always #5 clk = ~clk;

  des_key_schedule #(.ROUNDS(16)) dut0 (
    .clk(clk), .rst(rst), .key_valid(key_valid0), .key_ready(key_ready0), .key(key0),
    .decrypt(dec0), .rk_valid(rk_valid0), .rk_ready(rk_ready0), .rk(rk0),
    .rk_round(rk_round0), .rk_last(rk_last0), .parity_err(parity_err0)
  );

  des_key_schedule #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst), .key_valid(key_valid2), .key_ready(key_ready2), .key(key2),
    .decrypt(dec2), .rk_valid(rk_valid2), .rk_ready(rk_ready2), .rk(rk2),
    .rk_round(rk_round2), .rk_last(rk_last2), .parity_err(parity_err2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Consume round keys at every handshake and compare against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rk_valid0 && rk_ready0) begin
      if (sb0.size() == 0) check("unexpected_rk0", 64'(sb0.size()), 64'd1);
      else begin
        e = sb0.pop_front();
        check("rk0", 64'(rk0), 64'(e.rk));
        check("rk_round0", 64'(rk_round0), 64'(e.rnd));
        check("rk_last0", 64'(rk_last0), 64'(e.last));
      end
    end
    if (rk_valid2 && rk_ready2) begin
      if (sb2.size() == 0) check("unexpected_rk2", 64'(sb2.size()), 64'd1);
      else begin
        e = sb2.pop_front();
        check("rk2", 64'(rk2), 64'(e.rk));
        check("rk_round2", 64'(rk_round2), 64'(e.rnd));
        check("rk_last2", 64'(rk_last2), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit which, input logic dec, input int n);
    exp_t e;
    int idx;
    for (int i = 0; i < n; i++) begin
      idx    = dec ? 15 - i : i;
      e.rk   = KT[idx];
      e.rnd  = 4'(idx);
      e.last = (i == n - 1);
      if (which) sb2.push_back(e);
      else sb0.push_back(e);
    end
  endtask

  task automatic send(input bit which, input logic [63:0] k, input logic dec);
    int n;
    n = 0;
    while (((which ? key_ready2 : key_ready0) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("key_ready_timeout", 64'(n), 64'd0);
    if (which) begin key2 = k; dec2 = dec; key_valid2 = 1'b1; end
    else begin key0 = k; dec0 = dec; key_valid0 = 1'b1; end
    tick();
    key_valid0 = 1'b0;
    key_valid2 = 1'b0;
  endtask

  task automatic drain(input bit which, output int cycles);
    cycles = 0;
    while (((which ? sb2.size() : sb0.size()) != 0) && cycles < 100) begin
      tick();
      cycles++;
    end
    check("drain_timeout", 64'(which ? sb2.size() : sb0.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    tick();
    tick();
    check("rst_key_ready", 64'(key_ready0), 64'd1);
    check("rst_rk_valid", 64'(rk_valid0), 64'd0);
    check("rst_rk_last", 64'(rk_last0), 64'd0);
    check("rst_parity_err", 64'(parity_err0), 64'd0);
    check("rst_rk_round", 64'(rk_round0), 64'd0);
    check("rst_rk", 64'(rk0), 64'd0);
    rst = 1'b0;
    tick();

    // Encrypt run at full throughput.
    push(1'b0, 1'b0, 16);
    send(1'b0, KEY_GOOD, 1'b0);
    check("enc_latency_valid", 64'(rk_valid0), 64'd1);
    check("enc_key_ready_low", 64'(key_ready0), 64'd0);
    drain(1'b0, cyc);
    check("enc_throughput", 64'(cyc), 64'd16);
    check("enc_key_ready_back", 64'(key_ready0), 64'd1);
    check("enc_rk_valid_off", 64'(rk_valid0), 64'd0);

    // Decrypt run.
    push(1'b0, 1'b1, 16);
    send(1'b0, KEY_GOOD, 1'b1);
    check("dec_first_round", 64'(rk_round0), 64'd15);
    drain(1'b0, cyc);
    check("dec_throughput", 64'(cyc), 64'd16);

    // Stall on the first key for five cycles.
    push(1'b0, 1'b0, 16);
    send(1'b0, KEY_GOOD, 1'b0);
    rk_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_rk", 64'(rk0), 64'(KT[0]));
      check("stall_round", 64'(rk_round0), 64'd0);
      check("stall_valid", 64'(rk_valid0), 64'd1);
    end
    rk_ready0 = 1'b1;
    drain(1'b0, cyc);

    // Reset after seven keys have been taken.
    push(1'b0, 1'b0, 16);
    send(1'b0, KEY_GOOD, 1'b0);
    n = 0;
    while (sb0.size() > 9 && n < 50) begin
      tick();
      n++;
    end
    check("mid_run_progress", 64'(sb0.size()), 64'd9);
    rk_ready0 = 1'b0;
    rst = 1'b1;
    sb0.delete();
    tick();
    check("mrst_rk_valid", 64'(rk_valid0), 64'd0);
    check("mrst_key_ready", 64'(key_ready0), 64'd1);
    check("mrst_rk", 64'(rk0), 64'd0);
    rst = 1'b0;
    rk_ready0 = 1'b1;
    tick();
    check("mrst_no_valid", 64'(rk_valid0), 64'd0);
    push(1'b0, 1'b0, 16);
    send(1'b0, KEY_GOOD, 1'b0);
    check("mrst_restart_round", 64'(rk_round0), 64'd0);
    drain(1'b0, cyc);

    // ROUNDS=2, both orderings.
    push(1'b1, 1'b0, 2);
    send(1'b1, KEY_GOOD, 1'b0);
    drain(1'b1, cyc);
    check("r2_enc_cycles", 64'(cyc), 64'd2);
    check("r2_enc_idle", 64'(key_ready2), 64'd1);
    push(1'b1, 1'b1, 2);
    send(1'b1, KEY_GOOD, 1'b1);
    drain(1'b1, cyc);
    check("r2_dec_cycles", 64'(cyc), 64'd2);
    for (int i = 0; i < 3; i++) tick();
    check("r2_no_extra", 64'(rk_valid2), 64'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
    send(1'b0, KEY_BAD, 1'b0);
    check("par_rejected_valid", 64'(rk_valid0), 64'd0);
    check("par_err_set", 64'(parity_err0), 64'd1);
    check("par_key_ready", 64'(key_ready0), 64'd1);
    tick();
    check("par_err_held", 64'(parity_err0), 64'd1);
    push(1'b0, 1'b0, 16);
    send(1'b0, KEY_GOOD, 1'b0);
    check("par_err_cleared", 64'(parity_err0), 64'd0);
    check("par_good_valid", 64'(rk_valid0), 64'd1);
    drain(1'b0, cyc);
`else
    push(1'b0, 1'b0, 16);
    send(1'b0, KEY_BAD, 1'b0);
    check("nopar_accepted", 64'(rk_valid0), 64'd1);
    check("nopar_err_zero", 64'(parity_err0), 64'd0);
    drain(1'b0, cyc);
`endif

    for (int i = 0; i < 3; i++) tick();
    check("final_idle", 64'(rk_valid0), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Sequential DES key-schedule generator. It accepts a 64-bit DES key over a valid/ready handshake and applies permuted choice 1 into 28-bit C/D halves. It then streams one 48-bit round key per handshake, produced through the rotation schedule and permuted choice 2. Encrypt and decrypt ordering are both supported, so decrypt keys need no buffering. It sits between the key input interface and the round datapath, and replaces per-round combinational PC1/PC2 replication.

## Interface

- `ROUNDS`, default 16: number of round keys emitted per key; legal range 1..16.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  `key`/`decrypt` are presented.
- `key_ready`  out  1  block can accept a key.
- `key`  in  [1:64]  DES key, standard numbering; bit 1 = MSB; bits 8,16,..,64 are parity.
- `decrypt`  in  1  0: emit K1..K_ROUNDS; 1: emit K16 downward, ROUNDS keys.
- `rk_valid`  out  1  `rk` holds a valid round key.
- `rk_ready`  in  1  consumer takes `rk`.
- `rk`  out  [1:48]  round key, standard numbering; bit 1 = MSB.
- `rk_round`  out  4  index of the key on `rk`, minus 1 (K1→0, K16→15).
- `rk_last`  out  1  current `rk` is the final key for this load.
- `parity_err`  out  1  key rejected for parity; see Configuration.

## Operation

- States:
  - IDLE: `key_ready`=1, `rk_valid`=0.
  - RUN: `key_ready`=0, `rk_valid`=1.
- Shift table `s[1..16]` = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1; the sum is 28.
- Key accept: `key_valid` & `key_ready`. On accept, PC1(`key`) gives C0 = bits 1..28 and D0 = bits 29..56. `decrypt` is latched in the same cycle.
  - Encrypt: C/D load with C0/D0 rotated left by `s[1]`, the value for K1. The round counter loads 1.
  - Decrypt: C/D load with C0/D0 unrotated, because K16 corresponds to a full 28-bit rotation. The round counter loads 16.
- `rk` = PC2({C,D}), taken combinationally from the C/D registers.
  - `rk_round` = counter − 1.
  - `rk_last` = 1 when the emitted count equals ROUNDS.
- Advance: `rk_valid` & `rk_ready` & !`rk_last`.
  - Encrypt: the counter increments, and C and D each rotate left by `s[new counter]`.
  - Decrypt: C and D each rotate right by `s[old counter]`, and the counter decrements.
- Last key: when `rk_valid` & `rk_ready` & `rk_last`, the block goes to IDLE.
- Stall: while `rk_valid` & !`rk_ready`, `rk`, `rk_round` and `rk_last` stay stable.
- C and D are 28 bits wide. Rotations wrap within each half only and never cross halves.

## Timing

- Reset values: state=IDLE, C=D=0, counter=0.
  - `key_ready`=1. `rk_valid`=0, `rk_last`=0, `parity_err`=0.
  - `rk_round`=0. `rk`=PC2(0)=0.
- Reset applied mid-RUN aborts the key. IDLE is reached on the next edge, and no further `rk_valid` follows.
- Latency: key accepted at edge N → `rk_valid`=1 with the first key after edge N.
- Throughput: one key per cycle while `rk_ready`=1, so ROUNDS keys take ROUNDS cycles.
- Return to IDLE: after the last handshake, `key_ready`=1 in the next cycle. The earliest next accept is one cycle after the last handshake.
- `key_valid` is ignored in RUN. The source holds it until `key_ready`.

## Configuration

- Macro: `DES_KEY_PARITY_CHECK_EN`.
- Defined:
  - On each accept attempt, every key byte is checked for odd parity.
  - If any byte has even parity, the key is rejected. The state stays IDLE, and `parity_err` is set to 1 from the next cycle.
  - A parity-clean accept clears `parity_err`. Reset also clears it.
- Undefined: no check is made. `parity_err` is tied to 0, and every key is accepted.

## Test plan

- Encrypt sequence:
  - Stimulus: `rst`; key=0x133457799BBCDFF1, decrypt=0, rk_ready=1.
  - Response: the cycle after accept, rk=0x1B02EFFC7072 with rk_round=0. The next cycle, rk=0x79AED9DBC9E5. The 16th key is 0xCB3D8B0E17F5 with rk_last=1. key_ready=1 the following cycle.
- Decrypt sequence:
  - Stimulus: same key, decrypt=1.
  - Response: the first key is 0xCB3D8B0E17F5 with rk_round=15. The last key is 0x1B02EFFC7072 with rk_round=0 and rk_last=1.
- Stall:
  - Stimulus: rk_ready=0 for 5 cycles after the first key.
  - Response: rk holds 0x1B02EFFC7072 and rk_round holds 0 throughout. The sequence resumes with K2 once rk_ready=1.
- Reset mid-run:
  - Stimulus: assert rst after 7 keys.
  - Response: the next cycle has rk_valid=0, key_ready=1 and rk=0. A new key then restarts at K1.
- ROUNDS:
  - Stimulus: ROUNDS=2.
  - Response: exactly 2 keys are emitted, and rk_last=1 on the second. With decrypt=1, the keys are K16 then K15.
- Parity (macro defined):
  - Stimulus: key=0x133457799BBCDFF0, whose last byte has even parity.
  - Response: rk_valid stays 0, and parity_err=1 the next cycle. Then presenting key=0x133457799BBCDFF1 is accepted and clears parity_err.
